// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
package regfile_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NRP   = 2;

  // A hardwired zero register never needs clearing, so the sweep starts at 1.
  function automatic int first_clr_idx(input int zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the register file one entry per cycle while busy.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] FIRST = AW'(first_clr_idx(ZERO_REG));
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Pointer holds at LAST on exit rather than wrapping.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = FIRST;
        end
      end
      RF_CLEAR: begin
        if (ptr == LAST) state_nxt = RF_IDLE;
        else             ptr_nxt   = ptr + 1'b1;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised NRP-read / 1-write register file with bulk clear.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRP      = RF_NRP,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                busy
);

  logic [NREGS-1:0][XLEN-1:0] mem;
  logic                       clr_we;
  logic [AW-1:0]              clr_addr;
  logic                       wr_ok;

  regfile_clear_seq #(.NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  // Clear port wins over the write port; clr_we == busy so writes during a sweep drop.
  always_ff @(posedge clk) begin
    if (rst)         mem <= '0;
    else if (clr_we) mem[clr_addr] <= '0;
    else if (wr_ok)  mem[waddr] <= wdata;
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = raddr[gi*AW +: AW];

    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (we && !busy && (ra == waddr)) rd = wdata;
`endif
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end

    assign rdata[gi*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench: NRP=4/ZERO_REG=1 main DUT plus a ZERO_REG=0 twin.
module tb_regfile_multiport;

  logic         clk = 1'b0;
  logic         rst, we, clr_req;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [19:0]  raddr;
  logic [127:0] rdata;
  logic         busy;

  logic [4:0]   raddr_z;
  logic [31:0]  rdata_z;
  logic         clr_req_z, busy_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(32), .NREGS(32), .NRP(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .busy(busy)
  );

  regfile_multiport #(.XLEN(32), .NREGS(32), .NRP(1), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_z), .rdata(rdata_z), .clr_req(clr_req_z), .busy(busy_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%0b exp=0", busy);
    end
    wr(5'd5, 32'h12345678);
    raddr = {4{5'd5}};
    #1;
    checks++;
    if (rdata[31:0] !== 32'h12345678) begin
      failures++; $display("FAIL reset_prewrite got=%h exp=12345678", rdata[31:0]);
    end
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr = {4{5'(a)}};
      #1;
      checks++;
      if (rdata !== 128'h0) begin
        failures++; $display("FAIL reset_r%0d got=%h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'hDEADBEEF);
    raddr = 20'h0; raddr_z = 5'd0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0) begin
      failures++; $display("FAIL zero_hardwired got=%h exp=00000000", rdata[31:0]);
    end
    checks++;
    if (rdata_z !== 32'hDEADBEEF) begin
      failures++; $display("FAIL zero_plain got=%h exp=deadbeef", rdata_z);
    end
  endtask

  task automatic test_multiport();
    wr(5'd1, 32'h11111111);
    wr(5'd10, 32'hABCDEF00);
    wr(5'd31, 32'h31313131);
    raddr = {5'd31, 5'd10, 5'd1, 5'd10};
    #1;
    checks++;
    if (rdata !== {32'h31313131, 32'hABCDEF00, 32'h11111111, 32'hABCDEF00}) begin
      failures++; $display("FAIL multiport got=%h exp=31313131abcdef0011111111abcdef00", rdata);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
    wr(5'd5, 32'h0BADF00D);
    raddr = {4{5'd5}};
    we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEBABE;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'hCAFEBABE;
`else
    exp_pre = 32'h0BADF00D;
`endif
    checks++;
    if (rdata[31:0] !== exp_pre) begin
      failures++; $display("FAIL bypass_pre got=%h exp=%h", rdata[31:0], exp_pre);
    end
    tick(); we = 1'b0;
    checks++;
    if (rdata[31:0] !== 32'hCAFEBABE) begin
      failures++; $display("FAIL bypass_post got=%h exp=cafebabe", rdata[31:0]);
    end
    // Forwarding must never leak through the zero register.
    raddr = 20'h0; we = 1'b1; waddr = 5'd0; wdata = 32'h55AA55AA;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0) begin
      failures++; $display("FAIL bypass_zero got=%h exp=00000000", rdata[31:0]);
    end
    tick(); we = 1'b0;
  endtask

  task automatic test_bulk_clear();
    int cnt;
    for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
    raddr = {5'd31, 5'd20, 5'd7, 5'd1};
    #1;
    checks++;
    if (rdata !== {32'd31, 32'd20, 32'd7, 32'd1}) begin
      failures++; $display("FAIL clr_fill got=%h", rdata);
    end
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL clr_busy_rise got=%0b exp=1", busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      raddr = {5'(cnt), 5'd31, 5'd7, 5'(31 - cnt)};
      we = (cnt == 3);  waddr = 5'd7; wdata = 32'hCAFEBABE;
      clr_req = (cnt == 10);
      #1;
      checks++;
      if (rdata !== 128'h0) begin
        failures++; $display("FAIL clr_read_busy cyc=%0d got=%h exp=0", cnt, rdata);
      end
      tick();
      cnt++;
    end
    we = 1'b0; clr_req = 1'b0;
    checks++;
    if (cnt != 31) begin
      failures++; $display("FAIL clr_busy_len got=%0d exp=31", cnt);
    end
    for (int a = 0; a < 32; a++) begin
      raddr = {4{5'(a)}};
      #1;
      checks++;
      if (rdata !== 128'h0) begin
        failures++; $display("FAIL clr_after_r%0d got=%h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    wr(5'd30, 32'h30303030);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rmc_busy_pre got=%0b exp=1", busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rmc_busy_post got=%0b exp=0", busy);
    end
    raddr = {4{5'd30}};
    #1;
    checks++;
    if (rdata !== 128'h0) begin
      failures++; $display("FAIL rmc_r30 got=%h exp=0", rdata);
    end
    wr(5'd5, 32'hCAFEBABE);
    raddr = {4{5'd5}};
    #1;
    checks++;
    if (rdata !== {4{32'hCAFEBABE}}) begin
      failures++; $display("FAIL rmc_write got=%h exp=cafebabe x4", rdata);
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; clr_req = 1'b0; clr_req_z = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; raddr_z = '0;
    test_reset();
    test_zero_reg();
    test_multiport();
    test_bypass();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
